// File: rtl/whack_pkg.sv
// Shared types and constants for the whack-a-mole round engine: FSM state
// encoding and the 16-bit mole-selection LFSR (x^16+x^14+x^13+x^11+1).
package whack_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SHOW = 3'd1,
        GAP  = 3'd2,
        LOG  = 3'd3,
        DONE = 3'd4
    } state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Galois form: bits 15,13,12,10 of the right-shifting register.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        logic [15:0] nxt;
        nxt = cur >> 1;
        if (cur[0]) begin
            nxt = nxt ^ LFSR_TAPS;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/whack_tick_div.sv
// Tick divider: counts 0..TICK_CYCLES-1 and pulses tick on the last count.
// clr restarts the interval so the next tick lands exactly TICK_CYCLES later.
module whack_tick_div #(
    parameter int unsigned TICK_CYCLES = 50000000
) (
    input  logic clk,
    input  logic Reset,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        if (clr || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments and a synchronous reset.
    always_ff @(posedge clk) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/whack_round_engine.sv
// Whack-a-mole round engine: lights one mole per round, credits hits, times
// moles and gaps in ticks, and logs the final score. Optional: MISS_PENALTY_EN.
module whack_round_engine
    import whack_pkg::*;
#(
    parameter int unsigned NUM_HOLES   = 4,
    parameter int unsigned SCORE_W     = 8,
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned TICK_CYCLES = 50000000,
    parameter int unsigned UP_TICKS    = 2,
    parameter int unsigned GAP_TICKS   = 1,
    parameter int unsigned NUM_ROUNDS  = 10
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic                 start,
    input  logic [NUM_HOLES-1:0] hit,
    output logic [NUM_HOLES-1:0] mole,
    output logic [SCORE_W-1:0]   score,
    output logic [7:0]           round_cnt,
    output logic                 game_active,
    output logic                 game_over,
    output logic                 hit_flag,
    output logic                 wren,
    output logic [ADDR_W-1:0]    address,
    output logic [SCORE_W-1:0]   data_result
);

    localparam int unsigned HOLE_W = $clog2(NUM_HOLES);
    localparam int unsigned TL_MAX = (UP_TICKS > GAP_TICKS) ? UP_TICKS : GAP_TICKS;
    localparam int unsigned TL_W   = $clog2(TL_MAX + 1);

    state_e               state_q,       state_d;
    logic [15:0]          lfsr_q,        lfsr_d;
    logic [HOLE_W-1:0]    hole_q,        hole_d;
    logic [TL_W-1:0]      ticks_left_q,  ticks_left_d;
    logic [NUM_HOLES-1:0] mole_q,        mole_d;
    logic [SCORE_W-1:0]   score_q,       score_d;
    logic [7:0]           round_cnt_q,   round_cnt_d;
    logic                 game_active_q, game_active_d;
    logic                 game_over_q,   game_over_d;
    logic                 hit_flag_q,    hit_flag_d;
    logic                 wren_q,        wren_d;
    logic [ADDR_W-1:0]    address_q,     address_d;
    logic [SCORE_W-1:0]   data_result_q, data_result_d;

    logic tick;
    logic entering;
    logic interval_done;
    logic correct_hit;
`ifdef MISS_PENALTY_EN
    logic wrong_hit;
`endif

    whack_tick_div #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_tick_div (
        .clk   (clk),
        .Reset (Reset),
        .clr   (entering),
        .tick  (tick)
    );

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d       = state_q;
        lfsr_d        = lfsr_next(lfsr_q);
        hole_d        = hole_q;
        ticks_left_d  = ticks_left_q;
        score_d       = score_q;
        round_cnt_d   = round_cnt_q;
        hit_flag_d    = 1'b0;
        address_d     = address_q;
        data_result_d = data_result_q;

        interval_done = tick && (ticks_left_q == TL_W'(1));
        correct_hit   = hit[hole_q];
`ifdef MISS_PENALTY_EN
        wrong_hit     = |(hit & ~mole_q);
`endif

        if (tick && (ticks_left_q != '0) && ((state_q == SHOW) || (state_q == GAP))) begin
            ticks_left_d = ticks_left_q - 1'b1;
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = SHOW;
                    score_d     = '0;
                    round_cnt_d = '0;
                end
            end
            SHOW: begin
                if (correct_hit) begin
                    score_d    = (score_q == '1) ? score_q : score_q + 1'b1;
                    hit_flag_d = 1'b1;
                    state_d    = GAP;
                end else begin
`ifdef MISS_PENALTY_EN
                    if (wrong_hit && (score_q != '0)) begin
                        score_d = score_q - 1'b1;
                    end
`endif
                    if (interval_done) begin
                        state_d = GAP;
                    end
                end
                if (state_d == GAP) begin
                    round_cnt_d = round_cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (interval_done) begin
                    state_d = (round_cnt_q < 8'(NUM_ROUNDS)) ? SHOW : LOG;
                end
            end
            LOG: begin
                state_d   = DONE;
                address_d = address_q + 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Each state entry restarts the tick divider and reloads the interval.
        entering = (state_d != state_q);
        if (entering && (state_d == SHOW)) begin
            hole_d       = lfsr_q[HOLE_W-1:0];
            ticks_left_d = TL_W'(UP_TICKS);
        end
        if (entering && (state_d == GAP)) begin
            ticks_left_d = TL_W'(GAP_TICKS);
        end
        if (entering && (state_d == LOG)) begin
            data_result_d = score_d;
        end

        mole_d        = (state_d == SHOW) ? (NUM_HOLES'(1) << hole_d) : '0;
        game_active_d = (state_d == SHOW) || (state_d == GAP);
        game_over_d   = (state_d == DONE);
        wren_d        = (state_d == LOG);
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q       <= IDLE;
            lfsr_q        <= LFSR_SEED;
            hole_q        <= '0;
            ticks_left_q  <= '0;
            mole_q        <= '0;
            score_q       <= '0;
            round_cnt_q   <= '0;
            game_active_q <= 1'b0;
            game_over_q   <= 1'b0;
            hit_flag_q    <= 1'b0;
            wren_q        <= 1'b0;
            address_q     <= '0;
            data_result_q <= '0;
        end else begin
            state_q       <= state_d;
            lfsr_q        <= lfsr_d;
            hole_q        <= hole_d;
            ticks_left_q  <= ticks_left_d;
            mole_q        <= mole_d;
            score_q       <= score_d;
            round_cnt_q   <= round_cnt_d;
            game_active_q <= game_active_d;
            game_over_q   <= game_over_d;
            hit_flag_q    <= hit_flag_d;
            wren_q        <= wren_d;
            address_q     <= address_d;
            data_result_q <= data_result_d;
        end
    end

    assign mole        = mole_q;
    assign score       = score_q;
    assign round_cnt   = round_cnt_q;
    assign game_active = game_active_q;
    assign game_over   = game_over_q;
    assign hit_flag    = hit_flag_q;
    assign wren        = wren_q;
    assign address     = address_q;
    assign data_result = data_result_q;

endmodule
